// File: rtl/hazard_ctrl.sv
// Pipeline hazard/redirect controller for the 5-stage MIPS datapath.
// Produces stall, flushes, IF redirect, EX forwarding selects and saturating event counters.
//
// state  | meaning
// RUN    | redirects accepted, normal hazard handling
// SHADOW | post-redirect window, further ex_redirect ignored
module hazard_ctrl #(
  parameter int SHADOW_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic [4:0]       mem_rd,
  input  logic             mem_we,
  input  logic             mem_is_load,
  input  logic [4:0]       wb_rd,
  input  logic             wb_we,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  output logic             stall,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             jump_cs,
  output logic [31:0]      next_pc,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, SHADOW} state_t;

  state_t           state_q, state_d;
  logic [2:0]       shadow_q, shadow_d;
  logic [31:0]      npc_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             load_use, accept, stall_i;
  logic [1:0]       fwd_a_i, fwd_b_i;

  function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                         input logic [4:0] m_rd, input logic m_we,
                                         input logic m_ld, input logic [4:0] w_rd,
                                         input logic w_we);
    logic [1:0] sel;
    sel = 2'b00;
    if (r != 5'd0) begin
      if (m_we && !m_ld && m_rd == r) sel = 2'b10;
      else if (w_we && w_rd == r)     sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    load_use = ex_we && ex_is_load && (ex_rd != 5'd0) &&
               ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    accept   = ex_redirect && (state_q == RUN);
    // a redirect squashes the ID instruction, so its load-use stall is moot
    stall_i  = load_use && !accept;
    fwd_a_i  = fwd_sel(ex_rs, mem_rd, mem_we, mem_is_load, wb_rd, wb_we);
    fwd_b_i  = fwd_sel(ex_rt, mem_rd, mem_we, mem_is_load, wb_rd, wb_we);
    case (state_q)
      RUN: begin
        if (accept) begin
          state_d  = SHADOW;
          shadow_d = 3'(SHADOW_CYCLES);
        end
      end
      SHADOW: begin
        shadow_d = shadow_q - 3'd1;
        if (shadow_q == 3'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      shadow_q    <= 3'd0;
      npc_q       <= 32'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      if (accept) npc_q <= ex_target;
      if (stall_i && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (accept && flush_cnt_q != '1)  flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  // outputs are forced low for the whole reset cycle, not just after the edge
  assign stall       = !reset && stall_i;
  assign flush_if_id = !reset && accept;
  assign flush_id_ex = !reset && (accept || load_use);
  assign jump_cs     = !reset && accept;
  assign next_pc     = reset ? 32'd0 : (accept ? ex_target : npc_q);
  assign fwd_a       = reset ? 2'b00 : fwd_a_i;
  assign fwd_b       = reset ? 2'b00 : fwd_b_i;
  assign stall_count = reset ? '0 : stall_cnt_q;
  assign flush_count = reset ? '0 : flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control producer for the 5-stage MIPS datapath. It generates the IF-stage control inputs (stall, jump_cs, next_pc) and the pipeline-register flush and forwarding selects.
- Detects load-use hazards between ID and EX and computes EX-operand forwarding from the EX/MEM and MEM/WB registers.
- Applies EX-resolved branch/jump redirects and holds a post-redirect shadow window.
- Keeps saturating stall and flush event counters for bring-up.

Parameters:
- SHADOW_CYCLES, 2: cycles after an accepted redirect during which a further ex_redirect is ignored (range 1-7).
- CNT_W, 16: width of the stall_count and flush_count counters.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- ex_rs  in  5  rs of the instruction in EX
- ex_rt  in  5  rt of the instruction in EX
- ex_rd  in  5  destination register of the EX instruction
- ex_we  in  1  EX instruction writes the register file
- ex_is_load  in  1  EX instruction is a load
- mem_rd  in  5  destination register in MEM
- mem_we  in  1  MEM instruction writes the register file
- mem_is_load  in  1  MEM instruction is a load
- wb_rd  in  5  destination register in WB
- wb_we  in  1  WB instruction writes the register file
- ex_redirect  in  1  EX has resolved a taken branch or jump
- ex_target  in  32  redirect target address
- stall  out  1  hold PC and IF/ID
- flush_if_id  out  1  zero IF/ID next edge
- flush_id_ex  out  1  insert bubble into ID/EX next edge
- jump_cs  out  1  IF selects next_pc
- next_pc  out  32  redirect address for IF
- fwd_a  out  2  EX SRC select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- fwd_b  out  2  EX TARG select, same encoding as fwd_a
- stall_count  out  CNT_W  saturating count of stall cycles
- flush_count  out  CNT_W  saturating count of accepted redirects

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- While reset is asserted, all outputs are 0: stall, flushes, jump_cs, next_pc = 0, fwd_a = fwd_b = 00, counters = 0. State is RUN and the shadow counter is 0.
- Register 0 never causes a hazard or a forward.
- Load-use hazard (combinational): ex_we & ex_is_load & ex_rd != 0 & ((id_use_rs & id_rs == ex_rd) | (id_use_rt & id_rt == ex_rd)).
  - It produces stall = 1 and flush_id_ex = 1 in the same cycle.
  - The stall lasts exactly one cycle per load, because the load advances to MEM at the next edge.
- Forwarding for an EX operand register r (combinational):
  - 10 if mem_we & !mem_is_load & mem_rd == r & r != 0;
  - else 01 if wb_we & wb_rd == r & r != 0;
  - else 00.
  - EX/MEM has priority over MEM/WB.
- Redirect acceptance:
  - A redirect is accepted when ex_redirect = 1 and state = RUN.
  - In the accepting cycle (combinational): jump_cs = 1, next_pc = ex_target, flush_if_id = 1, flush_id_ex = 1, stall = 0.
  - A redirect has priority over a simultaneous load-use stall, because the ID instruction is wrong-path.
- State machine:
  - RUN -> SHADOW on an accepted redirect; the shadow counter loads SHADOW_CYCLES.
  - SHADOW: ex_redirect is ignored (jump_cs = 0, no redirect flush). Load-use detection and forwarding still operate. The counter decrements each cycle, and the state returns to RUN on the edge where the counter reaches 1 -> 0.
- next_pc holds its last accepted value when jump_cs = 0; it resets to 0.
- stall_count increments on each cycle with stall = 1. flush_count increments on each accepted redirect. Both saturate at all-ones and do not wrap.
- Reset asserted mid-SHADOW returns the block to RUN on that edge, and outputs go to 0 in that cycle.

Test Plan:
- Reset then idle: reset = 1 for 2 cycles with random inputs -> all outputs 0. After release with no hazards -> stall = 0, fwd = 00, counters stay 0.
- Load-use: ex_is_load = 1, ex_we = 1, ex_rd = 8, id_rs = 8, id_use_rs = 1 for one cycle -> stall = 1 and flush_id_ex = 1 for exactly that cycle, stall_count = 1. Repeating with ex_rd = 0 -> no stall.
- Forwarding priority: ex_rs = 5, mem_rd = 5, mem_we = 1, wb_rd = 5, wb_we = 1 -> fwd_a = 10. Setting mem_is_load = 1 -> fwd_a = 01. Setting wb_we = 0 as well -> fwd_a = 00.
- Redirect: ex_redirect = 1, ex_target = 0x00000040 -> same cycle jump_cs = 1, next_pc = 0x40, both flushes = 1, flush_count = 1. With ex_redirect held high for the next 2 cycles -> jump_cs = 0. On the 3rd cycle a new redirect to 0x80 is accepted.
- Redirect plus load-use in the same cycle -> stall = 0, jump_cs = 1, stall_count unchanged.
- Saturation and mid-shadow reset: with CNT_W = 4, hold the hazard for 20 cycles -> stall_count = 15. Assert reset during SHADOW -> the next-cycle redirect is accepted immediately after reset is released.
